// File: rtl/fetch_if.sv
// ----------------------------------------------------------------------------
// fetch_if
// Bundles the signals around the fetch sequencer: the redirect input from the
// branch offset unit, the instruction-memory request/response port and the
// instruction stream toward decode. Two debug outputs expose the sequencer's
// internal state and buffer occupancy.
//
// Handshake semantics (all sampled on the rising clock edge):
//   - imem:  a request transfers when imem_req && imem_gnt. imem_addr is held
//            while imem_req is high and no grant has occurred, unless a redirect
//            is taken. imem_rvalid returns the one outstanding word no earlier
//            than the cycle after the grant.
//   - inst:  the buffer head pops when inst_valid && inst_ready. inst_valid
//            does not depend on inst_ready.
//   - redirect_valid is a single-cycle pulse with redirect_pc as the target.
//
// Modports:
//   slave  - the fetch sequencer side
//   master - the environment side (branch unit, imem, decode)
// ----------------------------------------------------------------------------
interface fetch_if #(
  parameter int AW = 16,
  parameter int DW = 32
);
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_gnt;
  logic          imem_rvalid;
  logic [DW-1:0] imem_rdata;
  logic          inst_valid;
  logic [DW-1:0] inst_data;
  logic [AW-1:0] inst_pc;
  logic          inst_ready;
  logic          misalign_err;
  logic [1:0]    state_dbg;
  logic [1:0]    count_dbg;

  modport slave (
    input  redirect_valid, redirect_pc, imem_gnt, imem_rvalid, imem_rdata,
           inst_ready,
    output imem_req, imem_addr, inst_valid, inst_data, inst_pc, misalign_err,
           state_dbg, count_dbg
  );

  modport master (
    output redirect_valid, redirect_pc, imem_gnt, imem_rvalid, imem_rdata,
           inst_ready,
    input  imem_req, imem_addr, inst_valid, inst_data, inst_pc, misalign_err,
           state_dbg, count_dbg
  );
endinterface

// File: rtl/fetch_sequencer.sv
// ----------------------------------------------------------------------------
// fetch_sequencer
// Holds the architectural fetch PC and issues one outstanding request at a time
// to instruction memory. Returned words land in a 2-entry {instruction, pc}
// FIFO toward decode. A redirect flushes the FIFO, drops any stale in-flight
// response and restarts fetch at the target; a non word-aligned target halts
// fetch and raises a sticky error until reset.
//
// Ports:
//   clk  - clock
//   rst  - asynchronous active-high reset
//   bus  - fetch_if.slave: redirect in, imem request/response, decode stream,
//          misalign_err, plus state_dbg/count_dbg debug outputs
// ----------------------------------------------------------------------------
module fetch_sequencer #(
  parameter int INST_MEMORY_ADDRESS_WIDTH = 16,
  parameter int RISC_V_DATA_WIDTH         = 32,
  parameter logic [INST_MEMORY_ADDRESS_WIDTH-1:0] RESET_PC = '0
) (
  input  logic    clk,
  input  logic    rst,
  fetch_if.slave  bus
);
  localparam int AW = INST_MEMORY_ADDRESS_WIDTH;
  localparam int DW = RISC_V_DATA_WIDTH;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_RESP  = 2'd1,
    S_DRAIN = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] req_pc_q;
  logic [1:0]    count_q, count_d;
  logic          req_q, req_d;
  logic          err_q, err_d;
  logic          rd_ptr_q, wr_ptr_q;
  logic [DW-1:0] buf_data_q [2];
  logic [AW-1:0] buf_pc_q [2];

  logic redir;
  logic misaligned;
  logic grant;
  logic push;
  logic pop;
  logic head_valid;

  // HALT always has an empty buffer (it is entered through a flush), but the
  // state term keeps inst_valid low there regardless.
  assign head_valid = (count_q != 2'd0) && (state_q != S_HALT);
  assign grant      = req_q && bus.imem_gnt;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    count_d    = count_q;
    err_d      = err_q;
    push       = 1'b0;
    pop        = 1'b0;
    redir      = bus.redirect_valid && (state_q != S_HALT);
    misaligned = (bus.redirect_pc[1:0] != 2'b00);

    if (redir) begin
      // Redirect wins over everything: flush, retarget, and decide whether a
      // response is still owed by memory for a request we no longer want.
      pc_d    = bus.redirect_pc;
      count_d = 2'd0;
      if (misaligned) begin
        err_d   = 1'b1;
        state_d = S_HALT;
      end else begin
        case (state_q)
          S_REQ:   state_d = grant ? S_DRAIN : S_REQ;
          S_RESP:  state_d = bus.imem_rvalid ? S_REQ : S_DRAIN;
          S_DRAIN: state_d = bus.imem_rvalid ? S_REQ : S_DRAIN;
          default: state_d = state_q;
        endcase
      end
    end else begin
      pop = head_valid && bus.inst_ready;
      case (state_q)
        S_REQ: begin
          if (grant) state_d = S_RESP;
        end
        S_RESP: begin
          if (bus.imem_rvalid) begin
            push    = 1'b1;
            pc_d    = pc_q + AW'(4);
            state_d = S_REQ;
          end
        end
        S_DRAIN: begin
          if (bus.imem_rvalid) state_d = S_REQ;
        end
        default: state_d = state_q;
      endcase
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end

    // The request is registered from the next state so it never asserts
    // while reset is held and only when a buffer slot will be free.
    req_d = (state_d == S_REQ) && (count_d < 2'd2);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_REQ;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
      count_q  <= 2'd0;
      req_q    <= 1'b0;
      err_q    <= 1'b0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        buf_data_q[i] <= '0;
        buf_pc_q[i]   <= '0;
      end
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
      req_q   <= req_d;
      err_q   <= err_d;
      if (grant) req_pc_q <= pc_q;
      if (push) begin
        buf_data_q[wr_ptr_q] <= bus.imem_rdata;
        buf_pc_q[wr_ptr_q]   <= req_pc_q;
      end
      if (redir) begin
        rd_ptr_q <= 1'b0;
        wr_ptr_q <= 1'b0;
      end else begin
        if (push) wr_ptr_q <= ~wr_ptr_q;
        if (pop)  rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

  assign bus.imem_req     = req_q;
  assign bus.imem_addr    = pc_q;
  assign bus.inst_valid   = head_valid;
  assign bus.inst_data    = buf_data_q[rd_ptr_q];
  assign bus.inst_pc      = buf_pc_q[rd_ptr_q];
  assign bus.misalign_err = err_q;
  assign bus.state_dbg    = state_q;
  assign bus.count_dbg    = count_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// ----------------------------------------------------------------------------
// tb_fetch_sequencer
// Directed scenarios plus a randomized phase around a memory responder and a
// reference model of the instruction stream decode should see: after reset or
// an aligned redirect the stream is target, target+4, ... (16-bit wrap), and
// each word's data is a fixed function of its address.
// ----------------------------------------------------------------------------
module tb_fetch_sequencer;
  localparam int AW = 16;
  localparam int DW = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_if #(.AW(AW), .DW(DW)) bus ();

  fetch_sequencer #(
    .INST_MEMORY_ADDRESS_WIDTH(AW),
    .RISC_V_DATA_WIDTH(DW),
    .RESET_PC(16'h0000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // ---------------- bookkeeping ----------------
  int compared   = 0;
  int mismatched = 0;

  // stimulus knobs
  int            gnt_pct, ready_pct, min_lat, max_lat, redir_pct;
  logic          force_redir;
  logic [AW-1:0] force_pc;
  logic          redir_on_rvalid;
  logic [AW-1:0] rvalid_redir_pc;
  logic          fired;

  // memory responder
  logic          pending;
  logic [AW-1:0] pend_addr;
  int            lat;

  // reference model: front of exp_q is the pc decode must see next
  logic [AW-1:0] exp_q[$];
  logic          halted;
  logic          redir_prev;
  int            pops;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {a ^ 16'hC3A5, a};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Sample point: negedge, outputs are stable flop values.
  task automatic wait_neg();
    @(negedge clk);
    if (!rst) begin
      check("count_le_2", 32'(bus.count_dbg <= 2'd2), 32'd1);
      if (halted) begin
        check("halt_req",   32'(bus.imem_req),     32'd0);
        check("halt_valid", 32'(bus.inst_valid),   32'd0);
        check("halt_err",   32'(bus.misalign_err), 32'd1);
      end else if (redir_prev) begin
        check("valid_after_redirect", 32'(bus.inst_valid), 32'd0);
      end
      if (bus.imem_req) check("one_outstanding", 32'(pending), 32'd0);
    end
  endtask

  // Drive inputs for the coming edge and advance the reference model.
  task automatic drive();
    logic          resp;
    logic          redir;
    logic          pop_now;
    logic [AW-1:0] rpc;
    logic [AW-1:0] e;
    resp = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = $urandom;
    if (pending) begin
      if (lat == 0) begin
        resp            = 1'b1;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = mem_word(pend_addr);
        pending         = 1'b0;
      end else begin
        lat--;
      end
    end
    bus.imem_gnt = (int'($urandom_range(99)) < gnt_pct);
    if (bus.imem_req && bus.imem_gnt) begin
      pending   = 1'b1;
      pend_addr = bus.imem_addr;
      lat       = int'($urandom_range(max_lat, min_lat));
    end
    bus.inst_ready = (int'($urandom_range(99)) < ready_pct);

    redir = 1'b0;
    rpc   = AW'($urandom) & ~AW'(3);
    if (force_redir) begin
      redir       = 1'b1;
      rpc         = force_pc;
      force_redir = 1'b0;
    end else if (redir_on_rvalid && resp) begin
      redir           = 1'b1;
      rpc             = rvalid_redir_pc;
      redir_on_rvalid = 1'b0;
      fired           = 1'b1;
    end else if (int'($urandom_range(99)) < redir_pct) begin
      redir = 1'b1;
    end
    bus.redirect_valid = redir;
    bus.redirect_pc    = redir ? rpc : AW'($urandom);

    pop_now = bus.inst_valid && bus.inst_ready && !(redir && !halted);
    if (pop_now) begin
      e = exp_q.pop_front();
      check("inst_pc", 32'(bus.inst_pc), 32'(e));
      check("inst_data", bus.inst_data, mem_word(e));
      exp_q.push_back(e + AW'(4));
      pops++;
    end
    redir_prev = redir && !halted;
    if (redir && !halted) begin
      exp_q.delete();
      exp_q.push_back(rpc);
      if (rpc[1:0] != 2'b00) halted = 1'b1;
    end
  endtask

  task automatic step();
    wait_neg();
    drive();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst                = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.imem_gnt       = 1'b0;
    bus.imem_rvalid    = 1'b0;
    bus.imem_rdata     = '0;
    bus.inst_ready     = 1'b0;
    pending            = 1'b0;
    lat                = 0;
    halted             = 1'b0;
    redir_prev         = 1'b0;
    force_redir        = 1'b0;
    redir_on_rvalid    = 1'b0;
    pops               = 0;
    exp_q.delete();
    exp_q.push_back(16'h0000);
    #1;
    check("rst_imem_req",  32'(bus.imem_req),     32'd0);
    check("rst_imem_addr", 32'(bus.imem_addr),    32'h0);
    check("rst_inst_valid",32'(bus.inst_valid),   32'd0);
    check("rst_inst_data", bus.inst_data,         32'h0);
    check("rst_inst_pc",   32'(bus.inst_pc),      32'h0);
    check("rst_misalign",  32'(bus.misalign_err), 32'd0);
    check("rst_count",     32'(bus.count_dbg),    32'd0);
    @(negedge clk);
    rst = 1'b0;
    wait_neg();
    check("first_req",  32'(bus.imem_req),  32'd1);
    check("first_addr", 32'(bus.imem_addr), 32'h0);
    drive();
  endtask

  task automatic wait_req(input logic [AW-1:0] a);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      wait_neg();
      if (bus.imem_req && bus.imem_addr == a) begin
        found = 1'b1;
        break;
      end
      drive();
    end
    check("reach_req", 32'(found), 32'd1);
    if (!found) wait_neg();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    gnt_pct = 100; ready_pct = 100; min_lat = 0; max_lat = 0; redir_pct = 0;
    force_redir = 1'b0; force_pc = '0; redir_on_rvalid = 1'b0;
    rvalid_redir_pc = '0; fired = 1'b0;
    pending = 1'b0; pend_addr = '0; lat = 0;
    halted = 1'b0; redir_prev = 1'b0; pops = 0;

    // free running, minimum latency
    do_reset();
    repeat (30) step();
    check("free_run_rate", 32'(pops >= 13), 32'd1);

    // backpressure: buffer fills to 2, request stays low
    ready_pct = 0;
    do_reset();
    repeat (6) step();
    repeat (6) begin
      wait_neg();
      check("bp_req_low", 32'(bus.imem_req), 32'd0);
      drive();
    end
    wait_neg();
    check("bp_count",   32'(bus.count_dbg), 32'd2);
    check("bp_head_pc", 32'(bus.inst_pc),   32'h0);
    drive();
    ready_pct = 100;
    step();
    wait_neg();
    check("resume_req",  32'(bus.imem_req),  32'd1);
    check("resume_addr", 32'(bus.imem_addr), 32'h8);
    drive();
    repeat (10) step();

    // redirect while the response for 0x0010 is outstanding
    do_reset();
    wait_req(16'h0010);
    min_lat = 3; max_lat = 3;
    drive();
    wait_neg();
    force_redir = 1'b1; force_pc = 16'h0040;
    drive();
    min_lat = 0; max_lat = 0;
    pops = 0;
    repeat (14) step();
    check("resp_redirect_pops", 32'(pops >= 3), 32'd1);

    // redirect in the same cycle as the grant
    do_reset();
    wait_req(16'h0008);
    min_lat = 2; max_lat = 2;
    force_redir = 1'b1; force_pc = 16'h0080;
    drive();
    min_lat = 0; max_lat = 0;
    wait_neg();
    check("drain_no_req", 32'(bus.imem_req), 32'd0);
    drive();
    pops = 0;
    repeat (12) step();
    check("gnt_redirect_pops", 32'(pops >= 2), 32'd1);

    // redirect in the same cycle as rvalid
    min_lat = 1; max_lat = 1;
    do_reset();
    fired = 1'b0; rvalid_redir_pc = 16'h0100; redir_on_rvalid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (fired) break;
    end
    check("rvalid_redirect_fired", 32'(fired), 32'd1);
    wait_neg();
    check("rv_redir_req",  32'(bus.imem_req),  32'd1);
    check("rv_redir_addr", 32'(bus.imem_addr), 32'h0100);
    drive();
    min_lat = 0; max_lat = 0;
    pops = 0;
    repeat (12) step();
    check("rvalid_redirect_pops", 32'(pops >= 2), 32'd1);

    // wrap-around at the top of the address space
    do_reset();
    wait_neg();
    force_redir = 1'b1; force_pc = 16'hFFFC;
    drive();
    pops = 0;
    repeat (12) step();
    check("wrap_pops", 32'(pops >= 3), 32'd1);

    // randomized traffic with aligned redirects
    gnt_pct = 70; ready_pct = 60; min_lat = 0; max_lat = 3; redir_pct = 4;
    do_reset();
    pops = 0;
    repeat (800) step();
    check("random_pops", 32'(pops >= 50), 32'd1);
    redir_pct = 0;

    // misaligned redirect halts until reset
    gnt_pct = 100; ready_pct = 100; min_lat = 0; max_lat = 2;
    do_reset();
    repeat (5) step();
    wait_neg();
    force_redir = 1'b1; force_pc = 16'h0042;
    drive();
    wait_neg();
    check("misalign_set", 32'(bus.misalign_err), 32'd1);
    drive();
    gnt_pct = 50; ready_pct = 50; redir_pct = 20;
    repeat (15) step();
    redir_pct = 0; gnt_pct = 100; ready_pct = 100; max_lat = 0;
    do_reset();
    pops = 0;
    repeat (10) step();
    check("post_halt_pops", 32'(pops >= 3), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
